// File: rtl/addsub_div_seq.sv
// ============================================================================
// addsub_div_seq
// ----------------------------------------------------------------------------
// Sequential restoring divider. It is built around one shared adder/subtractor
// that stays in subtract mode and produces one quotient bit per clock. A start
// pulse launches an operation, and the results stay in registers until the next
// accepted start.
//
// Optional feature macro: ADDSUB_DIV_SIGNED_EN
//   defined   : operands are two's complement. The quotient truncates toward
//               zero and the remainder takes the sign of the dividend.
//   undefined : unsigned only. No sign logic is built.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous, active-high reset
//   start        in   1      request; sampled only in IDLE or DONE
//   dividend     in   WIDTH  numerator, captured on the accepted start edge
//   divisor      in   WIDTH  denominator, captured on the accepted start edge
//   busy         out  1      high while iterating (RUN)
//   done         out  1      high for the single cycle spent in DONE
//   quotient     out  WIDTH  registered result
//   remainder    out  WIDTH  registered result
//   div_by_zero  out  1      registered flag, updated with quotient/remainder
//
// Also contains adder_subtractor_8bits, a ripple-carry adder/subtractor. Its
// width is set by a parameter, even though the name says 8 bits.
// ============================================================================

// ----------------------------------------------------------------------------
// adder_subtractor_8bits
//   a, b  : operands
//   k     : 0 = add, 1 = subtract (a + ~b + 1)
//   sum   : result
//   cout  : carry out. In subtract mode it is 1 when a >= b (no borrow).
// ----------------------------------------------------------------------------
module adder_subtractor_8bits #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             k,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] b_x;

   // k doubles as the carry-in, which completes the two's complement of b.
   assign carry[0] = k;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign b_x[gi]       = b[gi] ^ k;
         assign sum[gi]       = a[gi] ^ b_x[gi] ^ carry[gi];
         assign carry[gi + 1] = (a[gi] & b_x[gi]) | (carry[gi] & (a[gi] ^ b_x[gi]));
      end
   endgenerate

   assign cout = carry[WIDTH];
endmodule

// ----------------------------------------------------------------------------
module addsub_div_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] q_reg;          // dividend shifting out / quotient shifting in
   logic [WIDTH-1:0] d_reg;          // captured divisor (magnitude)
   logic [WIDTH-1:0] r_reg;          // partial remainder
   logic [CNT_W-1:0] cnt_reg;        // iterations left
   logic [WIDTH-1:0] quotient_reg;
   logic [WIDTH-1:0] remainder_reg;
   logic             div_by_zero_reg;

   // ---------------------------------------------------------------------
   // One restoring step. The shifted remainder is WIDTH+1 bits wide:
   // {carry_hi, shift_rem}. If carry_hi is set, that value is at least 2^W,
   // so it always exceeds the divisor. In that case the modulo-2^W
   // difference is still the exact (and smaller) result.
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] shift_rem;
   logic             carry_hi;
   logic [WIDTH-1:0] diff;
   logic             cout;
   logic             take_sub;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] r_next;

   assign shift_rem = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
   assign carry_hi  = r_reg[WIDTH-1];

   adder_subtractor_8bits #(.WIDTH(WIDTH)) u_addsub (
      .a    (shift_rem),
      .b    (d_reg),
      .k    (1'b1),
      .sum  (diff),
      .cout (cout)
   );

   assign take_sub = carry_hi | cout;
   assign r_next   = take_sub ? diff : shift_rem;
   assign q_next   = {q_reg[WIDTH-2:0], take_sub};

   // ---------------------------------------------------------------------
   // Operand conditioning and result sign fix-up
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH-1:0] divisor_mag;
   logic [WIDTH-1:0] q_final;
   logic [WIDTH-1:0] r_final;

`ifdef ADDSUB_DIV_SIGNED_EN
   logic q_neg_reg;                  // quotient must be negated at DONE entry
   logic r_neg_reg;                  // remainder must be negated at DONE entry

   // -(-2^(W-1)) wraps back to 2^(W-1). Read as unsigned, that is still the
   // correct magnitude.
   assign dividend_mag = dividend[WIDTH-1] ? -dividend : dividend;
   assign divisor_mag  = divisor[WIDTH-1]  ? -divisor  : divisor;
   assign q_final      = q_neg_reg ? -q_next : q_next;
   assign r_final      = r_neg_reg ? -r_next : r_next;
`else
   assign dividend_mag = dividend;
   assign divisor_mag  = divisor;
   assign q_final      = q_next;
   assign r_final      = r_next;
`endif

   // ---------------------------------------------------------------------
   // Control FSM and datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         q_reg           <= '0;
         d_reg           <= '0;
         r_reg           <= '0;
         cnt_reg         <= '0;
         quotient_reg    <= '0;
         remainder_reg   <= '0;
         div_by_zero_reg <= 1'b0;
`ifdef ADDSUB_DIV_SIGNED_EN
         q_neg_reg       <= 1'b0;
         r_neg_reg       <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (start) begin
                  q_reg   <= dividend_mag;
                  d_reg   <= divisor_mag;
                  r_reg   <= '0;
                  cnt_reg <= CNT_W'(WIDTH);
`ifdef ADDSUB_DIV_SIGNED_EN
                  q_neg_reg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  r_neg_reg <= dividend[WIDTH-1];
`endif
                  if (divisor != '0) begin
                     state_reg <= RUN;
                  end else begin
                     // Divide by zero: finish at once and report the raw
                     // dividend as the remainder.
                     state_reg       <= DONE;
                     quotient_reg    <= '1;
                     remainder_reg   <= dividend;
                     div_by_zero_reg <= 1'b1;
                  end
               end else if (state_reg == DONE) begin
                  state_reg <= IDLE;
               end
            end

            RUN: begin
               // A start pulse here is ignored on purpose.
               q_reg   <= q_next;
               r_reg   <= r_next;
               cnt_reg <= cnt_reg - 1'b1;
               if (cnt_reg == CNT_W'(1)) begin
                  state_reg       <= DONE;
                  quotient_reg    <= q_final;
                  remainder_reg   <= r_final;
                  div_by_zero_reg <= 1'b0;
               end
            end

            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy        = (state_reg == RUN);
   assign done        = (state_reg == DONE);
   assign quotient    = quotient_reg;
   assign remainder   = remainder_reg;
   assign div_by_zero = div_by_zero_reg;

endmodule
